// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Pure declarations: no latency and no backpressure of its own.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
// Purely combinational (zero latency); it has no flow control of its own.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rd,
  output logic             o_load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = i_id_uses_rs1 && (i_ex_rd == i_id_rs1);
  assign w_hit_rs2  = i_id_uses_rs2 && (i_ex_rd == i_id_rs2);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign o_load_use = i_ex_memread && (i_ex_rd != X0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer driving PC/IF_ID/ID_EX/EX_MEM enables; outputs decode state+inputs in the same cycle.
// dmem_busy freezes all stages; HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_branch_taken,
  input  logic             i_dmem_busy,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_idex_write,
  output logic             o_exmem_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_halted,
  output logic [1:0]       o_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      o_stall_cycles,
  output logic [31:0]      o_flush_cycles
`endif
);

  localparam int FC_W = cnt_w(FLUSH_CYCLES);
  localparam int WC_W = cnt_w(MEM_TIMEOUT);
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LIMIT   = WC_W'(MEM_TIMEOUT);

  state_t          r_state;
  state_t          w_state_nxt;
  state_t          r_ret_state;
  state_t          w_ret_state_nxt;
  logic [FC_W-1:0] r_flush_cnt;
  logic [FC_W-1:0] w_flush_cnt_nxt;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_wait_cnt_nxt;
  logic            r_halted;
  logic            w_halted_nxt;
  logic            w_load_use;

  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_write;
  logic w_exmem_write;
  logic w_ifid_flush;
  logic w_idex_bubble;

  load_use_detect u_load_use_detect (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_uses_rs1 (i_id_uses_rs1),
    .i_id_uses_rs2 (i_id_uses_rs2),
    .i_ex_memread  (i_ex_memread),
    .i_ex_rd       (i_ex_rd),
    .o_load_use    (w_load_use)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ret_state_nxt = r_ret_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_halted_nxt    = r_halted;
    case (r_state)
      RUN: begin
        if (i_dmem_busy) begin
          w_state_nxt     = MEM_WAIT;
          w_ret_state_nxt = RUN;
          w_wait_cnt_nxt  = WC_W'(1);
        end else if (i_branch_taken && (FLUSH_CYCLES > 1)) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FLUSH_RELOAD;
        end
      end
      FLUSH: begin
        // flush_cnt is held across a freeze so the squash resumes where it left off
        if (i_dmem_busy) begin
          w_state_nxt     = MEM_WAIT;
          w_ret_state_nxt = FLUSH;
          w_wait_cnt_nxt  = WC_W'(1);
        end else if (r_flush_cnt <= FC_W'(1)) begin
          w_state_nxt     = RUN;
          w_flush_cnt_nxt = '0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!i_dmem_busy) begin
          w_state_nxt    = r_ret_state;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WAIT_LIMIT) begin
          w_state_nxt  = HALT;
          w_halted_nxt = 1'b1;
        end else if (r_wait_cnt != '1) begin
          w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
        end
      end
      default: begin
        w_state_nxt = HALT;
      end
    endcase
  end

  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_write  = 1'b1;
    w_exmem_write = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    case (r_state)
      RUN: begin
        if (i_dmem_busy) begin
          {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
        end else if (i_branch_taken) begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end else if (w_load_use) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end
      end
      FLUSH: begin
        if (i_dmem_busy) begin
          {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
        end else begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end
      end
      default: begin
        // MEM_WAIT stays frozen through the cycle busy drops; HALT is frozen until reset
        {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
      end
    endcase
    if (RST) begin
      {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
    end
  end

  assign o_pc_write    = w_pc_write;
  assign o_ifid_write  = w_ifid_write;
  assign o_idex_write  = w_idex_write;
  assign o_exmem_write = w_exmem_write;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_bubble = w_idex_bubble;
  assign o_halted      = r_halted;
  assign o_state       = r_state;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_ifid_flush && (r_flush_cycles != '1)) begin
        r_flush_cycles <= r_flush_cycles + 32'd1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl compared against a flag/counter reference model.
// Directed hazard scenarios first, then random traffic with busy bursts and occasional reset.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int FC = 2;
  localparam int MT = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_memread, branch_taken, dmem_busy;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             ifid_flush, idex_bubble, halted;
  logic [1:0]       state;
`ifdef HAZARD_PERF_EN
  logic [31:0]      stall_cycles, flush_cycles;
`endif

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_uses_rs1  (id_uses_rs1),
    .i_id_uses_rs2  (id_uses_rs2),
    .i_ex_memread   (ex_memread),
    .i_ex_rd        (ex_rd),
    .i_branch_taken (branch_taken),
    .i_dmem_busy    (dmem_busy),
    .o_pc_write     (pc_write),
    .o_ifid_write   (ifid_write),
    .o_idex_write   (idex_write),
    .o_exmem_write  (exmem_write),
    .o_ifid_flush   (ifid_flush),
    .o_idex_bubble  (idex_bubble),
    .o_halted       (halted),
    .o_state        (state)
`ifdef HAZARD_PERF_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_flush_cycles (flush_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending squash cycles, frozen-episode length, halt flag.
  bit      m_halt;
  bit      m_wait;
  int      m_flush_left;
  int      m_busy_run;
  longint  m_stall;
  longint  m_flush;

  task automatic model_reset();
    m_halt       = 1'b0;
    m_wait       = 1'b0;
    m_flush_left = 0;
    m_busy_run   = 0;
    m_stall      = 0;
    m_flush      = 0;
  endtask

  task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit mr, input int rd, input bit br, input bit busy);
    id_rs1       = REG_W'(rs1);
    id_rs2       = REG_W'(rs2);
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    ex_memread   = mr;
    ex_rd        = REG_W'(rd);
    branch_taken = br;
    dmem_busy    = busy;
  endtask

  // Called just after a rising edge with inputs driven; checks at the falling edge.
  task automatic step();
    bit lu, e_pc, e_ifid, e_idex, e_exmem, e_fl, e_bub;
    int e_state;
    lu = ex_memread && (ex_rd != 0) &&
         ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
    e_fl  = 1'b0;
    e_bub = 1'b0;
    if (RST || m_halt || m_wait || dmem_busy) begin
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
    end else if (m_flush_left > 0 || branch_taken) begin
      e_fl  = 1'b1;
      e_bub = 1'b1;
    end else if (lu) begin
      e_pc  = 1'b0;
      e_ifid = 1'b0;
      e_bub = 1'b1;
    end
    e_state = m_halt ? 3 : m_wait ? 2 : (m_flush_left > 0) ? 1 : 0;

    @(negedge CLK);
    check_val("pc_write",    32'(pc_write),    32'(e_pc));
    check_val("ifid_write",  32'(ifid_write),  32'(e_ifid));
    check_val("idex_write",  32'(idex_write),  32'(e_idex));
    check_val("exmem_write", 32'(exmem_write), 32'(e_exmem));
    check_val("ifid_flush",  32'(ifid_flush),  32'(e_fl));
    check_val("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    check_val("halted",      32'(halted),      32'(m_halt));
    check_val("state",       32'(state),       32'(e_state));
`ifdef HAZARD_PERF_EN
    check_val("stall_cycles", stall_cycles, 32'(m_stall));
    check_val("flush_cycles", flush_cycles, 32'(m_flush));
`endif

    if (RST) begin
      model_reset();
    end else begin
      if (!e_pc) m_stall++;
      if (e_fl)  m_flush++;
      if (m_halt) begin
        // sticky until reset
      end else if (m_wait) begin
        if (!dmem_busy) begin
          m_wait     = 1'b0;
          m_busy_run = 0;
        end else if (m_busy_run == MT) begin
          m_halt = 1'b1;
          m_wait = 1'b0;
        end else begin
          m_busy_run++;
        end
      end else if (dmem_busy) begin
        m_wait     = 1'b1;
        m_busy_run = 1;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (branch_taken) begin
        m_flush_left = FC - 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    int busy_hold;
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge CLK);
    #1;
    step();                               // reset state
    RST = 1'b0;
    idle(2);

    set_in(5, 0, 1, 0, 1, 5, 0, 0); step();   // load-use on rs1
    idle(1);
    set_in(5, 0, 1, 0, 1, 0, 0, 0); step();   // rd = x0
    set_in(1, 5, 1, 0, 1, 5, 0, 0); step();   // rs2 match but unused
    set_in(1, 5, 0, 1, 1, 5, 0, 0); step();   // load-use on rs2

    set_in(0, 0, 0, 0, 0, 0, 1, 0); step();   // branch
    set_in(5, 0, 1, 0, 1, 5, 1, 0); step();   // wrong path: ignored
    idle(2);

    set_in(0, 0, 0, 0, 0, 0, 1, 0); step();   // branch then busy during FLUSH
    for (int k = 0; k < 3; k++) begin set_in(0, 0, 0, 0, 0, 0, 0, 1); step(); end
    idle(4);

    for (int k = 0; k < 8; k++) begin set_in(0, 0, 0, 0, 0, 0, 0, 1); step(); end
    idle(3);                              // halted stays sticky
    RST = 1'b1; idle(1); RST = 1'b0;
    idle(1);

    set_in(5, 0, 1, 0, 1, 5, 1, 0); step();   // branch beats load-use
    idle(3);

    busy_hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (busy_hold == 0 && $urandom_range(0, 99) < 8) busy_hold = $urandom_range(1, 7);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 3), $urandom_range(0, 99) < 15, busy_hold > 0);
      if (busy_hold > 0) busy_hold--;
      RST = ($urandom_range(0, 99) < 2);
      step();
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
